// File: rtl/sdr_dq_pipe_if.sv
// rtl/sdr_dq_pipe_if.sv - DQ datapath bundle between command controller, pins and host read stream
interface sdr_dq_pipe_if #(
  parameter int DSIZE = 32
);
  logic               wr_en;
  logic [DSIZE-1:0]   datain;
  logic [DSIZE/8-1:0] dm;
  logic               rd_cmd;
  logic [DSIZE-1:0]   dqin;
  logic [DSIZE-1:0]   dqout;
  logic [DSIZE/8-1:0] dqm;
  logic               dq_oe;
  logic [DSIZE-1:0]   rdata;
  logic               rvalid;
  logic               rlast;
  logic               rd_busy;
  logic               rd_err;
  logic               bus_coll;

  modport master (
    output wr_en, datain, dm, rd_cmd, dqin,
    input  dqout, dqm, dq_oe, rdata, rvalid, rlast, rd_busy, rd_err, bus_coll
  );

  modport slave (
    input  wr_en, datain, dm, rd_cmd, dqin,
    output dqout, dqm, dq_oe, rdata, rvalid, rlast, rd_busy, rd_err, bus_coll
  );
endinterface

// File: rtl/sdr_dq_pipe.sv
// rtl/sdr_dq_pipe.sv - SDRAM DQ write alignment and CAS-latency read capture
module sdr_dq_pipe #(
  parameter int DSIZE     = 32,
  parameter int WR_LAT    = 2,
  parameter int CAS_LAT   = 3,
  parameter int BURST_LEN = 4
) (
  input logic          clk,
  input logic          rst,
  sdr_dq_pipe_if.slave bus
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int GW = $clog2(BURST_LEN) + 1;

  logic               wv [WR_LAT];
  logic [DSIZE-1:0]   wd [WR_LAT];
  logic [DSIZE/8-1:0] wm [WR_LAT];
  logic               oe_next;

  logic [CAS_LAT-1:0] tok, tok_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [GW-1:0]      gap, gap_next;
  logic               accept, tail, capture;

  logic [DSIZE-1:0]   rdata_q;
  logic               rvalid_q, rlast_q, rd_busy_q, rd_err_q, bus_coll_q;

  // Masks are zeroed at entry so idle (read) cycles never mask the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WR_LAT; i++) begin
        wv[i] <= 1'b0;
        wd[i] <= '0;
        wm[i] <= '0;
      end
    end else begin
      wv[0] <= bus.wr_en;
      wd[0] <= bus.datain;
      wm[0] <= bus.wr_en ? bus.dm : '0;
      for (int i = 1; i < WR_LAT; i++) begin
        wv[i] <= wv[i-1];
        wd[i] <= wd[i-1];
        wm[i] <= wm[i-1];
      end
    end
  end

  generate
    if (WR_LAT == 1) begin : g_oe_direct
      assign oe_next = bus.wr_en;
    end else begin : g_oe_staged
      assign oe_next = wv[WR_LAT-2];
    end
  endgenerate

  always_comb begin
    accept   = 1'b0;
    tail     = 1'b0;
    capture  = 1'b0;
    cnt_next = '0;
    gap_next = '0;
    tok_next = '0;

    accept  = bus.rd_cmd && (gap == '0);
    tail    = tok[CAS_LAT-1];
    // A token leaving the pipe while the last beat is pending reloads seamlessly.
    capture = tail || (cnt > CW'(1));

    if (tail)
      cnt_next = CW'(BURST_LEN);
    else if (cnt != '0)
      cnt_next = cnt - CW'(1);

    if (accept)
      gap_next = GW'(BURST_LEN - 1);
    else if (gap != '0)
      gap_next = gap - GW'(1);

    tok_next = {tok[CAS_LAT-2:0], accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok        <= '0;
      cnt        <= '0;
      gap        <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rd_busy_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      bus_coll_q <= 1'b0;
    end else begin
      tok        <= tok_next;
      cnt        <= cnt_next;
      gap        <= gap_next;
      rvalid_q   <= capture;
      rlast_q    <= capture && (cnt_next == CW'(1));
      rd_busy_q  <= (|tok_next) || (cnt_next != '0);
      rd_err_q   <= bus.rd_cmd && !accept;
      bus_coll_q <= capture && oe_next;
      if (capture)
        rdata_q <= bus.dqin;
    end
  end

  assign bus.dqout    = wd[WR_LAT-1];
  assign bus.dqm      = wm[WR_LAT-1];
  assign bus.dq_oe    = wv[WR_LAT-1];
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rlast    = rlast_q;
  assign bus.rd_busy  = rd_busy_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.bus_coll = bus_coll_q;
endmodule

// File: tb/tb_sdr_dq_pipe.sv
// tb/tb_sdr_dq_pipe.sv - scoreboard bench for sdr_dq_pipe
module tb_sdr_dq_pipe;
  localparam int DSIZE     = 32;
  localparam int WR_LAT    = 2;
  localparam int CAS_LAT   = 3;
  localparam int BURST_LEN = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sdr_dq_pipe_if #(.DSIZE(DSIZE)) bus ();

  sdr_dq_pipe #(
    .DSIZE(DSIZE), .WR_LAT(WR_LAT), .CAS_LAT(CAS_LAT), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    errors   = 0;
  int    checks   = 0;
  int    cyc      = 0;
  int    last_acc = -100;
  beat_t sb[$];
  beat_t mon_b;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int c);
    return {16'hC0DE, c[15:0]};
  endfunction

  // DQIN sampled at an edge equals pat(cycle count before that edge).
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    bus.dqin = pat(cyc);
  end

  always @(posedge clk) begin
    #2;
    if (bus.rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 64'd1, 64'd0);
      end else begin
        mon_b = sb.pop_front();
        check("rdata", bus.rdata, mon_b.data);
        check("rlast", bus.rlast, mon_b.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_edge(input bit cmd);
    bit exp_err = 1'b0;
    if (cmd) begin
      if (cyc - last_acc >= BURST_LEN) begin
        last_acc = cyc;
        for (int k = 0; k < BURST_LEN; k++)
          sb.push_back('{pat(cyc + CAS_LAT + k), (k == BURST_LEN - 1)});
      end else begin
        exp_err = 1'b1;
      end
    end
    bus.rd_cmd = cmd;
    tick();
    check("rd_err", bus.rd_err, exp_err);
    bus.rd_cmd = 1'b0;
  endtask

  task automatic check_all_zero(input string pre);
    check({pre, "_dqout"},    bus.dqout,    0);
    check({pre, "_dqm"},      bus.dqm,      0);
    check({pre, "_dq_oe"},    bus.dq_oe,    0);
    check({pre, "_rdata"},    bus.rdata,    0);
    check({pre, "_rvalid"},   bus.rvalid,   0);
    check({pre, "_rlast"},    bus.rlast,    0);
    check({pre, "_rd_busy"},  bus.rd_busy,  0);
    check({pre, "_rd_err"},   bus.rd_err,   0);
    check({pre, "_bus_coll"}, bus.bus_coll, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    bus.wr_en  = 1'b0;
    bus.datain = '0;
    bus.dm     = '0;
    bus.rd_cmd = 1'b0;
    bus.dqin   = '0;

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // write alignment
    bus.wr_en  = 1'b1;
    bus.datain = 32'hA5A5_0001;
    bus.dm     = 4'h2;
    tick();
    check("wr_oe_early", bus.dq_oe, 0);
    bus.wr_en  = 1'b0;
    bus.datain = 32'h0;
    bus.dm     = 4'hF;
    tick();
    check("wr_dqout", bus.dqout, 32'hA5A5_0001);
    check("wr_dqm",   bus.dqm,   4'h2);
    check("wr_oe",    bus.dq_oe, 1);
    tick();
    check("wr_oe_off",  bus.dq_oe, 0);
    check("wr_dqm_off", bus.dqm,   0);
    bus.dm = 4'h0;

    // single read
    rd_edge(1'b1);
    check("busy_rise", bus.rd_busy, 1);
    repeat (6) tick();
    check("busy_hold", bus.rd_busy, 1);
    tick();
    check("busy_fall", bus.rd_busy, 0);
    check("single_drained", sb.size(), 0);

    // seamless reads four cycles apart
    rd_edge(1'b1);
    repeat (3) tick();
    rd_edge(1'b1);
    repeat (7) tick();
    check("seamless_drained", sb.size(), 0);
    check("seamless_idle", bus.rd_busy, 0);

    // overlap reject
    rd_edge(1'b1);
    tick();
    rd_edge(1'b1);
    tick();
    check("rd_err_pulse", bus.rd_err, 0);
    repeat (8) tick();
    check("overlap_drained", sb.size(), 0);

    // write drive colliding with read beat 0
    rd_edge(1'b1);
    tick();
    bus.wr_en  = 1'b1;
    bus.datain = 32'hDEAD_BEEF;
    tick();
    bus.wr_en = 1'b0;
    check("coll_before", bus.bus_coll, 0);
    tick();
    check("coll_pulse",  bus.bus_coll, 1);
    check("coll_rvalid", bus.rvalid,   1);
    tick();
    check("coll_after",  bus.bus_coll, 0);
    repeat (6) tick();

    // random command stream against the accept model
    for (int i = 0; i < 60; i++)
      rd_edge($urandom_range(0, 2) == 0);
    repeat (10) tick();
    check("random_drained", sb.size(), 0);

    // reset in the middle of a burst with a write in flight
    rd_edge(1'b1);
    tick();
    bus.wr_en  = 1'b1;
    bus.datain = 32'h1234_5678;
    bus.dm     = 4'h5;
    tick();
    bus.wr_en = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("post_rst_busy",   bus.rd_busy, 0);
    check("post_rst_rvalid", bus.rvalid,  0);
    check("final_drained",   sb.size(),   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdr_dq_pipe.md
# sdr_dq_pipe

Parametrised SDRAM DQ datapath between the SDRAM command controller and the external DQ/DQM pins. The write side delays host write data and byte masks by a programmable number of register stages so they align with the WRITE command on the pins. The read side tracks in-flight READ commands through a CAS-latency pipeline and captures a burst of DQ beats into a registered host read stream with valid/last flags. It also flags read commands that would overlap and write/read bus collisions.

## Interface
- DSIZE, 32, data width in bits; multiple of 8
- WR_LAT, 2, write-path register stages, 1..4
- CAS_LAT, 3, SDRAM CAS latency in cycles, 2..3
- BURST_LEN, 4, beats per read burst, 1, 2, 4 or 8
- CLK  in  1  system clock; all logic on the rising edge
- RESET  in  1  asynchronous, active-high reset
- WR_EN  in  1  current DATAIN/DM form a write beat
- DATAIN  in  DSIZE  host write data
- DM  in  DSIZE/8  host byte masks, 1 = masked
- RD_CMD  in  1  single-cycle pulse, READ command issued to the SDRAM this cycle
- DQIN  in  DSIZE  data from the SDRAM DQ pins
- DQOUT  out  DSIZE  data to the DQ pins
- DQM  out  DSIZE/8  DQM pins
- DQ_OE  out  1  DQ output enable
- RDATA  out  DSIZE  captured read beat
- RVALID  out  1  RDATA valid this cycle
- RLAST  out  1  final beat of the burst, qualified by RVALID
- RD_BUSY  out  1  read in flight
- RD_ERR  out  1  one-cycle pulse: RD_CMD rejected
- BUS_COLL  out  1  one-cycle pulse: write drive overlapped a read beat

## Operation
- Write path: a WR_LAT-deep shift register holds {WR_EN, DATAIN, DM}. The last stage drives DQ_OE = stage WR_EN and DQOUT = stage data. DQM = stage DM when stage WR_EN = 1, otherwise all zeros, so reads are not masked.
- Read token pipe: a shift register of CAS_LAT bits. An accepted RD_CMD inserts a 1 at the head. When the token leaves the tail, a beat counter loads BURST_LEN and the capture window opens.
- Capture: while the window is open, DQIN is registered into RDATA with RVALID = 1 each cycle. The counter decrements, and RLAST = 1 on the beat where the counter reaches 1. The window closes after BURST_LEN beats.
- Accept rule: an RD_CMD is accepted only if no RD_CMD was accepted in the previous BURST_LEN-1 cycles. This is implemented with a saturating gap counter, so back-to-back bursts spaced exactly BURST_LEN apart stream with no gap.
- Rejected RD_CMD: no token is inserted, and RD_ERR pulses for one cycle. For BURST_LEN = 1, every RD_CMD is accepted.
- RD_BUSY = OR of all token bits, plus the counter being nonzero.
- BUS_COLL pulses for one cycle whenever DQ_OE is 1 on an edge at which a read beat is sampled. The captured beat is still delivered.
- States: beat counter 0 = IDLE, 1..BURST_LEN = CAPTURE. A token arriving exactly when the counter reaches 1 reloads the counter without a bubble.
- Reset (any time, including mid-burst): all pipes, counters and outputs are cleared. DQOUT = 0, DQM = 0, DQ_OE = 0, RDATA = 0, and RVALID, RLAST, RD_BUSY, RD_ERR, BUS_COLL = 0. In-flight reads are dropped and never produce RVALID after reset is released.

## Timing
- Edge n is the rising edge that samples inputs; RD_CMD/WR_EN are sampled at edge 0.
- Write latency: DQOUT/DQM/DQ_OE reflect the edge-0 inputs after edge WR_LAT-1, i.e. WR_LAT register stages. With WR_LAT = 2 they are valid in the cycle after edge 1.
- Read: beat k (k = 0..BURST_LEN-1) is sampled from DQIN at edge CAS_LAT+k and appears on RDATA with RVALID after that same edge. Read latency from RD_CMD to first RVALID is CAS_LAT cycles. RLAST accompanies beat BURST_LEN-1.
- RD_ERR is asserted after edge 0 for a rejected RD_CMD sampled at edge 0.
- RD_BUSY rises after edge 0 and falls after edge CAS_LAT+BURST_LEN, unless another read is pending.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Write align, WR_LAT = 2: WR_EN = 1, DATAIN = 0xA5A5_0001, DM = 0x2 at edge 0 -> DQOUT = 0xA5A5_0001, DQM = 0x2, DQ_OE = 1 after edge 1 only; DQM = 0 the next cycle.
- Single read, CAS_LAT = 3, BURST_LEN = 4: RD_CMD at edge 0, DQIN = 0x10..0x13 at edges 3..6 -> RVALID after edges 3..6 with RDATA 0x10..0x13, RLAST with 0x13, RD_BUSY low after edge 7.
- Seamless reads: RD_CMD at edges 0 and 4 -> 8 consecutive RVALID beats, RLAST after edges 6 and 10, RD_ERR never asserted.
- Overlap reject: RD_CMD at edges 0 and 2 -> RD_ERR pulses after edge 2; only 4 beats delivered.
- Collision: WR_EN = 1 at edge 2 (WR_LAT = 2) plus RD_CMD at edge 0 -> BUS_COLL pulses once after edge 3; beat 0 is still delivered.
- Reset mid-burst: RESET high during edge 4 of a read -> all outputs 0 immediately; no RVALID after release even if DQIN toggles.
